// File: rtl/ir_nec_pkg.sv
`default_nettype none
// ============================================================================
// Package  : ir_nec_pkg
// Purpose  : FSM state encoding and NEC pulse-width windows (microseconds).
// Revision : 1.0
// ============================================================================
package ir_nec_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LEAD_LOW  = 3'd1,
        S_LEAD_HIGH = 3'd2,
        S_BIT_LOW   = 3'd3,
        S_BIT_HIGH  = 3'd4,
        S_STOP      = 3'd5
    } state_t;

    localparam int          c_us_w          = 14;
    localparam logic [13:0] c_us_sat        = 14'd16383;

    localparam logic [13:0] c_lead_low_min  = 14'd8000;
    localparam logic [13:0] c_lead_low_max  = 14'd10000;
    localparam logic [13:0] c_lead_frm_min  = 14'd4000;
    localparam logic [13:0] c_lead_frm_max  = 14'd5000;
    localparam logic [13:0] c_lead_rep_min  = 14'd2000;
    localparam logic [13:0] c_lead_rep_max  = 14'd2500;
    localparam logic [13:0] c_bit_low_min   = 14'd300;
    localparam logic [13:0] c_bit_low_max   = 14'd800;
    localparam logic [13:0] c_bit0_min      = 14'd300;
    localparam logic [13:0] c_bit0_max      = 14'd800;
    localparam logic [13:0] c_bit1_min      = 14'd1300;
    localparam logic [13:0] c_bit1_max      = 14'd1900;
    localparam logic [13:0] c_stop_max      = 14'd1000;

    // Longest width each state may legally see before it is considered stuck.
    function automatic logic [13:0] state_max(input state_t s);
        case (s)
            S_LEAD_LOW:  return c_lead_low_max;
            S_LEAD_HIGH: return c_lead_frm_max;
            S_BIT_LOW:   return c_bit_low_max;
            S_BIT_HIGH:  return c_bit1_max;
            S_STOP:      return c_stop_max;
            default:     return c_us_sat;
        endcase
    endfunction

    function automatic logic in_window(input logic [13:0] v,
                                       input logic [13:0] lo,
                                       input logic [13:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ir_nec_receiver_us_tick.sv
`default_nettype none
// ============================================================================
// Module   : us_tick
// Purpose  : Free-running prescaler producing a one-cycle strobe every 1 us.
// Revision : 1.0
// ============================================================================
module us_tick
    import ir_nec_pkg::*;
#(
    parameter int CLK_PER_US = 50
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_us_tick
);

    localparam int              c_w    = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [c_w-1:0]  c_last = c_w'(CLK_PER_US - 1);

    logic [c_w-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_us_tick = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/ir_nec_receiver.sv
`default_nettype none
// ============================================================================
// Module   : ir_nec_receiver
// Purpose  : NEC infrared decoder: 32-bit frames and repeat codes, 1 us timing.
// Revision : 1.0
// ============================================================================
module ir_nec_receiver
    import ir_nec_pkg::*;
#(
    parameter int CLK_PER_US = 50,
    parameter int CHECK_INV  = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_red,
    output logic [31:0] o_data,
    output logic        o_intr,
    output logic        o_repeat,
    output logic        o_err
);

    logic        r_sync1, r_sync2, r_red_d;
    logic        w_fall, w_rise, w_edge;
    logic        w_us_tick;
    logic [13:0] r_us_cnt, w_width;
    state_t      r_state, w_state_next;
    logic [30:0] r_sr;
    logic [4:0]  r_bit_cnt;
    logic [31:0] w_frame;
    logic [31:0] r_data;
    logic        r_intr, r_repeat, r_err;
    logic        w_lead_low_ok, w_lead_frm, w_lead_rep, w_bit_low_ok;
    logic        w_bit0, w_bit1, w_bit_ok, w_last_bit, w_csum_ok, w_timeout;
    logic        w_sr_clr, w_shift, w_intr, w_repeat, w_err;

    // Idle-high reset values keep reset from looking like a burst start.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_red_d <= 1'b1;
        end else begin
            r_sync1 <= i_red;
            r_sync2 <= r_sync1;
            r_red_d <= r_sync2;
        end
    end

    assign w_fall = r_red_d & ~r_sync2;
    assign w_rise = ~r_red_d & r_sync2;
    assign w_edge = w_fall | w_rise;

    us_tick #(.CLK_PER_US(CLK_PER_US)) u_us_tick (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .o_us_tick (w_us_tick)
    );

    // Width includes the tick of the current cycle so a pulse of N us reads N.
    assign w_width = (r_us_cnt == c_us_sat) ? c_us_sat : r_us_cnt + {13'd0, w_us_tick};

    always_ff @(posedge i_clk) begin
        if (i_rst || w_edge) begin
            r_us_cnt <= '0;
        end else begin
            r_us_cnt <= w_width;
        end
    end

    assign w_lead_low_ok = in_window(w_width, c_lead_low_min, c_lead_low_max);
    assign w_lead_frm    = in_window(w_width, c_lead_frm_min, c_lead_frm_max);
    assign w_lead_rep    = in_window(w_width, c_lead_rep_min, c_lead_rep_max);
    assign w_bit_low_ok  = in_window(w_width, c_bit_low_min,  c_bit_low_max);
    assign w_bit0        = in_window(w_width, c_bit0_min,     c_bit0_max);
    assign w_bit1        = in_window(w_width, c_bit1_min,     c_bit1_max);
    assign w_bit_ok      = w_bit0 | w_bit1;
    assign w_last_bit    = (r_bit_cnt == 5'd31);
    assign w_timeout     = (w_width > state_max(r_state));

    // Only 31 bits are stored; the 32nd arrives with the final fall.
    assign w_frame   = {r_sr, w_bit1};
    assign w_csum_ok = (CHECK_INV == 0) ||
                       ((w_frame[31:24] == ~w_frame[23:16]) &&
                        (w_frame[15:8]  == ~w_frame[7:0]));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_fall) w_state_next = S_LEAD_LOW;
            end
            S_LEAD_LOW: begin
                if (w_rise)         w_state_next = w_lead_low_ok ? S_LEAD_HIGH : S_IDLE;
                else if (w_timeout) w_state_next = S_IDLE;
            end
            S_LEAD_HIGH: begin
                if (w_fall) begin
                    if (w_lead_frm)      w_state_next = S_BIT_LOW;
                    else if (w_lead_rep) w_state_next = S_STOP;
                    else                 w_state_next = S_IDLE;
                end else if (w_timeout) begin
                    w_state_next = S_IDLE;
                end
            end
            S_BIT_LOW: begin
                if (w_rise)         w_state_next = w_bit_low_ok ? S_BIT_HIGH : S_IDLE;
                else if (w_timeout) w_state_next = S_IDLE;
            end
            S_BIT_HIGH: begin
                if (w_fall) begin
                    if (!w_bit_ok)       w_state_next = S_IDLE;
                    else if (w_last_bit) w_state_next = S_STOP;
                    else                 w_state_next = S_BIT_LOW;
                end else if (w_timeout) begin
                    w_state_next = S_IDLE;
                end
            end
            S_STOP: begin
                if (w_rise || w_timeout) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_sr_clr = 1'b0;
        w_shift  = 1'b0;
        w_intr   = 1'b0;
        w_repeat = 1'b0;
        w_err    = 1'b0;
        case (r_state)
            S_LEAD_LOW: begin
                w_err = w_timeout && !w_rise;
            end
            S_LEAD_HIGH: begin
                if (w_fall) begin
                    w_sr_clr = w_lead_frm;
                    w_repeat = !w_lead_frm && w_lead_rep;
                    w_err    = !w_lead_frm && !w_lead_rep;
                end else begin
                    w_err = w_timeout;
                end
            end
            S_BIT_LOW: begin
                w_err = w_rise ? !w_bit_low_ok : w_timeout;
            end
            S_BIT_HIGH: begin
                if (w_fall) begin
                    w_shift = w_bit_ok;
                    w_intr  = w_bit_ok && w_last_bit && w_csum_ok;
                    w_err   = !w_bit_ok || (w_last_bit && !w_csum_ok);
                end else begin
                    w_err = w_timeout;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sr      <= '0;
            r_bit_cnt <= '0;
            r_data    <= '0;
            r_intr    <= 1'b0;
            r_repeat  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (w_sr_clr) begin
                r_sr      <= '0;
                r_bit_cnt <= '0;
            end else if (w_shift) begin
                r_sr      <= w_frame[30:0];
                r_bit_cnt <= r_bit_cnt + 5'd1;
            end
            if (w_intr) r_data <= w_frame;
            r_intr   <= w_intr;
            r_repeat <= w_repeat;
            r_err    <= w_err;
        end
    end

    assign o_data   = r_data;
    assign o_intr   = r_intr;
    assign o_repeat = r_repeat;
    assign o_err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ir_nec_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_ir_nec_receiver
// Purpose  : Directed self-checking bench for ir_nec_receiver (1 clk = 1 us).
// Revision : 1.0
// ============================================================================
module tb_ir_nec_receiver;

    logic        clk = 1'b0;
    logic        rst;
    logic        red;
    logic [31:0] data;
    logic        intr, rep, err;

    int cyc = 0;
    int n_intr = 0, n_rep = 0, n_err = 0, last_intr_cyc = 0;
    int s_intr, s_rep, s_err;
    int n_checks = 0, n_fail = 0;
    int stop_cyc, lat;
    int lead_lo, lead_hi, bit_lo, zero_hi, one_hi;

    ir_nec_receiver #(.CLK_PER_US(1), .CHECK_INV(1)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_red    (red),
        .o_data   (data),
        .o_intr   (intr),
        .o_repeat (rep),
        .o_err    (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Counting high samples also catches a strobe that lasts more than one cycle.
    always @(negedge clk) begin
        if (intr) begin
            n_intr        <= n_intr + 1;
            last_intr_cyc <= cyc;
        end
        if (rep) n_rep <= n_rep + 1;
        if (err) n_err <= n_err + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic lvl, input int dur);
        red = lvl;
        repeat (dur) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        hold(1'b0, bit_lo);
        hold(1'b1, b ? one_hi : zero_hi);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        hold(1'b0, lead_lo);
        hold(1'b1, lead_hi);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        send_byte(b3);
        stop_cyc = cyc;
        hold(1'b0, 560);
        hold(1'b1, 200);
    endtask

    task automatic snap();
        s_intr = n_intr;
        s_rep  = n_rep;
        s_err  = n_err;
    endtask

    initial begin
        red = 1'b1;
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("reset_data",   data, 32'h0);
        check("reset_intr",   {31'd0, intr}, 32'd0);
        check("reset_repeat", {31'd0, rep},  32'd0);
        check("reset_err",    {31'd0, err},  32'd0);
        rst = 1'b0;
        hold(1'b1, 100);

        // Ideal NEC timing, addr 0x00 cmd 0x45.
        lead_lo = 9000; lead_hi = 4500; bit_lo = 560; zero_hi = 560; one_hi = 1690;
        snap();
        send_frame(8'h00, 8'hFF, 8'h45, 8'hBA);
        lat = last_intr_cyc - stop_cyc;
        check("frameA_data",    data, 32'h00FFA25D);
        check("frameA_intr",    n_intr - s_intr, 1);
        check("frameA_err",     n_err - s_err, 0);
        check("frameA_repeat",  n_rep - s_rep, 0);
        check("frameA_latency", (lat == 3 || lat == 4) ? 32'd1 : 32'd0, 1);

        snap();
        hold(1'b0, 9000);
        hold(1'b1, 2250);
        hold(1'b0, 560);
        hold(1'b1, 200);
        check("repeat_pulse", n_rep - s_rep, 1);
        check("repeat_intr",  n_intr - s_intr, 0);
        check("repeat_err",   n_err - s_err, 0);
        check("repeat_data",  data, 32'h00FFA25D);

        lead_lo = 8500; lead_hi = 4200; bit_lo = 400; zero_hi = 400; one_hi = 1400;
        snap();
        send_frame(8'h00, 8'hFF, 8'h00, 8'h00);
        check("badinv_err",  n_err - s_err, 1);
        check("badinv_intr", n_intr - s_intr, 0);
        check("badinv_data", data, 32'h00FFA25D);

        snap();
        hold(1'b0, 7000);
        hold(1'b1, 3000);
        check("shortlead_err",  n_err - s_err, 0);
        check("shortlead_intr", n_intr - s_intr, 0);
        check("shortlead_rep",  n_rep - s_rep, 0);

        snap();
        hold(1'b0, lead_lo);
        hold(1'b1, lead_hi);
        for (int i = 0; i < 10; i++) send_bit(1'b0);
        hold(1'b0, bit_lo);
        hold(1'b1, 3000);
        check("stuck_err",  n_err - s_err, 1);
        check("stuck_intr", n_intr - s_intr, 0);

        snap();
        hold(1'b0, lead_lo);
        hold(1'b1, lead_hi);
        hold(1'b0, 300);
        hold(1'b1, 1950);
        hold(1'b0, 400);
        hold(1'b1, 1000);
        check("high1950_err",  n_err - s_err, 1);
        check("high1950_intr", n_intr - s_intr, 0);

        hold(1'b0, lead_lo);
        hold(1'b1, lead_hi);
        send_bit(1'b1);
        send_bit(1'b0);
        hold(1'b0, bit_lo);
        hold(1'b1, 50);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_data",   data, 32'h0);
        check("midrst_intr",   {31'd0, intr}, 32'd0);
        check("midrst_repeat", {31'd0, rep},  32'd0);
        check("midrst_err",    {31'd0, err},  32'd0);
        rst = 1'b0;
        snap();
        hold(1'b1, 2000);
        check("postrst_err", n_err - s_err, 0);

        // Every window at its inclusive edge: leader 8000/4000, bit low 300, 0 = 300, 1 = 1900.
        lead_lo = 8000; lead_hi = 4000; bit_lo = 300; zero_hi = 300; one_hi = 1900;
        snap();
        send_frame(8'h01, 8'hFE, 8'h08, 8'hF7);
        check("frameB_data", data, 32'h807F10EF);
        check("frameB_intr", n_intr - s_intr, 1);
        check("frameB_err",  n_err - s_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
